// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the two CPU requesters, the arbiter and the downstream memory port.
// slave  : the arbiter's view (consumes requests and memory responses).
// master : the surrounding environment's view (CPU ports plus memory model).
interface mem_port_arbiter_if;
    logic        inst_req;
    logic        inst_wr;
    logic [1:0]  inst_size;
    logic [31:0] inst_addr;
    logic [31:0] inst_wdata;
    logic        inst_addr_ok;
    logic        inst_data_ok;

    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;

    logic [31:0] cpu_rdata;

    logic        mem_req;
    logic        mem_wr;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_addr_ok;
    logic        mem_data_ok;
    logic [31:0] mem_rdata;

    modport slave (
        input  inst_req, inst_wr, inst_size, inst_addr, inst_wdata,
        input  data_req, data_wr, data_size, data_addr, data_wdata,
        output inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok, cpu_rdata,
        output mem_req, mem_wr, mem_size, mem_addr, mem_wdata,
        input  mem_addr_ok, mem_data_ok, mem_rdata
    );

    modport master (
        output inst_req, inst_wr, inst_size, inst_addr, inst_wdata,
        output data_req, data_wr, data_size, data_addr, data_wdata,
        input  inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok, cpu_rdata,
        input  mem_req, mem_wr, mem_size, mem_addr, mem_wdata,
        output mem_addr_ok, mem_data_ok, mem_rdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-port (inst/data) to single memory port arbiter, one transaction outstanding.
// Optional macro ARB_ROUND_ROBIN_EN: contested grants alternate between ports;
// when undefined, contested grants always go to the data port.
module mem_port_arbiter (
    input  logic                  clk,
    input  logic                  resetn,
    mem_port_arbiter_if.slave     bus
);

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    state_t      state;
    state_t      state_nxt;

    logic        grant_data;
    logic        lat_wr;
    logic [1:0]  lat_size;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;

    logic        pick_data;
    logic        accept;
    logic        done;

`ifdef ARB_ROUND_ROBIN_EN
    logic        last_data;

    // Contested requests go to the port that did not win last time.
    always_comb begin
        pick_data = bus.data_req;
        if (bus.data_req && bus.inst_req)
            pick_data = ~last_data;
    end

    // Remember which port won the most recent grant; resets to inst.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            last_data <= 1'b0;
        else if (accept)
            last_data <= pick_data;
    end
`else
    // Fixed priority: data port wins whenever it requests.
    always_comb begin
        pick_data = bus.data_req;
    end
`endif

    // Accept is suppressed while reset is held so no addr_ok leaks out during reset.
    assign accept = (state == IDLE) && resetn && (bus.inst_req || bus.data_req);
    assign done   = (state == DATA) && bus.mem_data_ok;

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state logic; stray memory handshakes outside their phase are ignored.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (accept)          state_nxt = ADDR;
            ADDR:    if (bus.mem_addr_ok) state_nxt = DATA;
            DATA:    if (bus.mem_data_ok) state_nxt = IDLE;
            default:                      state_nxt = IDLE;
        endcase
    end

    // Capture the granted port and its request fields at accept time.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            grant_data <= 1'b0;
            lat_wr     <= 1'b0;
            lat_size   <= '0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
        end else if (accept) begin
            grant_data <= pick_data;
            if (pick_data) begin
                lat_wr    <= bus.data_wr;
                lat_size  <= bus.data_size;
                lat_addr  <= bus.data_addr;
                lat_wdata <= bus.data_wdata;
            end else begin
                lat_wr    <= bus.inst_wr;
                lat_size  <= bus.inst_size;
                lat_addr  <= bus.inst_addr;
                lat_wdata <= bus.inst_wdata;
            end
        end
    end

    // Output decode: accept/complete pulses and the downstream request.
    always_comb begin
        bus.inst_addr_ok = accept && !pick_data;
        bus.data_addr_ok = accept &&  pick_data;
        bus.inst_data_ok = done   && !grant_data;
        bus.data_data_ok = done   &&  grant_data;
        bus.cpu_rdata    = done ? bus.mem_rdata : '0;
        bus.mem_req      = (state == ADDR);
        bus.mem_wr       = lat_wr;
        bus.mem_size     = lat_size;
        bus.mem_addr     = lat_addr;
        bus.mem_wdata    = lat_wdata;
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 resetn  input  1  asynchronous, active-low reset.
REQ-003 inst_req / data_req  input  1 each  requester transaction request, held until that port's addr_ok.
REQ-004 inst_wr / data_wr  input  1 each  1 = write, 0 = read.
REQ-005 inst_size / data_size  input  2 each  0 = byte, 1 = half, 2 = word.
REQ-006 inst_addr / data_addr  input  32 each  byte address.
REQ-007 inst_wdata / data_wdata  input  32 each  write data.
REQ-008 inst_addr_ok / data_addr_ok  output  1 each  one-cycle accept pulse.
REQ-009 inst_data_ok / data_data_ok  output  1 each  one-cycle completion pulse.
REQ-010 cpu_rdata  output  32  read data, valid with either data_ok.
REQ-011 mem_req, mem_wr  output  1 each  downstream request and direction.
REQ-012 mem_size  output  2  downstream size.
REQ-013 mem_addr, mem_wdata  output  32 each  downstream address and write data.
REQ-014 mem_addr_ok, mem_data_ok  input  1 each  downstream accept and completion.
REQ-015 mem_rdata  input  32  downstream read data.

Function
REQ-016 The block SHALL use FSM states IDLE, ADDR, DATA, with one transaction outstanding at most.
REQ-017 IDLE: if any req is high, grant one port, latch its wr/size/addr/wdata, pulse that port's addr_ok in the same cycle, and go to ADDR; otherwise stay in IDLE.
REQ-018 ADDR: mem_req = 1 with the latched fields stable; on mem_addr_ok go to DATA, else stay.
REQ-019 DATA: mem_req = 0; on mem_data_ok pulse the granted port's data_ok combinationally, drive cpu_rdata = mem_rdata, and go to IDLE.
REQ-020 Minimum latency SHALL be: accept in cycle N, mem_req in N+1, data_ok no earlier than N+2, next grant no earlier than the cycle after data_ok.
REQ-021 The losing requester SHALL receive no addr_ok and SHALL be served on a later IDLE cycle while its req stays high.
REQ-022 mem_addr_ok outside ADDR and mem_data_ok outside DATA SHALL be ignored.
REQ-023 Only the granted port SHALL see data_ok; the other port's data_ok SHALL be 0.
REQ-024 cpu_rdata SHALL be 0 whenever no data_ok is asserted.
REQ-025 Write transactions SHALL complete identically; cpu_rdata content on a write data_ok is don't-care.

Reset
REQ-026 While resetn = 0, state SHALL be IDLE and all outputs 0; the grant and latched fields SHALL clear to 0.
REQ-027 Reset asserted mid-transaction SHALL abandon that transaction; a late mem_data_ok after reset release SHALL be ignored.
REQ-028 The first grant SHALL occur no earlier than the first rising edge with resetn = 1.

Configuration
REQ-029 Macro ARB_ROUND_ROBIN_EN: when defined, simultaneous requests in IDLE SHALL go to the port not granted last; a last-grant register resets to "inst", so the first contested grant goes to data.
REQ-030 Without ARB_ROUND_ROBIN_EN, simultaneous requests SHALL always grant data (fixed priority) and no last-grant register SHALL exist.

Verification
REQ-031 Single inst read at 0xBFC00000, mem_addr_ok immediate, mem_data_ok one cycle later with 0x3C1D0001 -> inst_addr_ok at N, mem_req at N+1, inst_data_ok at N+2 with cpu_rdata = 0x3C1D0001.
REQ-032 inst_req and data_req (write 0xDEADBEEF to 0x80001000, size 2) raised together, fixed priority -> data granted first, mem_wr = 1, mem_wdata = 0xDEADBEEF; inst granted only after data_data_ok.
REQ-033 With ARB_ROUND_ROBIN_EN defined, both ports requesting continuously for four transactions -> grant order data, inst, data, inst.
REQ-034 mem_addr_ok held low for 5 cycles -> mem_req and mem_addr stay stable for 5 cycles, and no second addr_ok is issued.
REQ-035 Stray mem_data_ok pulses in IDLE and ADDR -> no data_ok output pulses.
REQ-036 resetn pulled low in DATA, then released, then mem_data_ok = 1 -> all outputs 0 and no data_ok issued.
